// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-RAM arbiter: FSM state encoding,
// MEM byte-count codes, default geometry and the byte-count decode helper.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 17;
  localparam int RAM_RD_LAT_DEF = 1;

  // mem_sel codes: byte count minus one
  localparam logic [1:0] MEM_SEL_1B  = 2'd0;
  localparam logic [1:0] MEM_SEL_2B  = 2'd1;
  localparam logic [1:0] MEM_SEL_ILL = 2'd2;
  localparam logic [1:0] MEM_SEL_4B  = 2'd3;

  // An instruction refill is always one full word
  localparam logic [2:0] IF_LEN = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } arb_state_e;

  // Byte count for a MEM request; the illegal code behaves as a full word
  function automatic logic [2:0] sel_to_len(input logic [1:0] sel);
    case (sel)
      MEM_SEL_1B:             return 3'd1;
      MEM_SEL_2B:             return 3'd2;
      MEM_SEL_ILL, MEM_SEL_4B: return 3'd4;
      default:                return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle of the arbiter: IF refill side, MEM-stage side and the byte-wide
// RAM port. slave = the arbiter, master = the surrounding core/RAM.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  // IF / icache side
  logic              if_miss_i;
  logic [31:0]       if_pc_i;
  logic              if_flush_i;
  logic              icache_we_o;
  logic [31:0]       icache_wpc_o;
  logic [31:0]       icache_winst_o;
  // MEM stage side
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_sel_i;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;
  // RAM port
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport slave (
    input  if_miss_i, if_pc_i, if_flush_i,
    output icache_we_o, icache_wpc_o, icache_winst_o,
    input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_done_o,
    output ram_a_o, ram_wr_o, ram_dout_o,
    input  ram_din_i
  );

  modport master (
    output if_miss_i, if_pc_i, if_flush_i,
    input  icache_we_o, icache_wpc_o, icache_winst_o,
    output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_done_o,
    input  ram_a_o, ram_wr_o, ram_dout_o,
    output ram_din_i
  );

endinterface

// File: rtl/mem_arbiter_ram_byte_seq.sv
// Byte sequencer for the RAM port: issues bytes base+0..base+len-1 one per
// cycle, captures read bytes RAM_RD_LAT cycles later and assembles them
// little-endian into a zero-extended 32-bit word. Issue and capture counters
// run independently; the arbiter FSM drives start/stop.
module mem_arbiter_ram_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RAM_RD_LAT = RAM_RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        start_len,
  input  logic [31:0]       start_wdata,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              issuing,
  output logic              issue_done,
  output logic              cap_done,
  output logic [31:0]       data
);

  logic                  busy_q;
  logic [ADDR_W-1:0]     base_q;
  logic [2:0]            len_q;
  logic [2:0]            issue_cnt_q;
  logic [2:0]            cap_cnt_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic [RAM_RD_LAT-1:0] pipe_q;
  logic                  capture;

  assign issuing    = busy_q && (issue_cnt_q != len_q);
  assign issue_done = busy_q && (issue_cnt_q == len_q);
  assign cap_done   = busy_q && (cap_cnt_q == len_q);
  assign capture    = busy_q && pipe_q[RAM_RD_LAT-1];
  assign ram_a      = base_q + ADDR_W'(issue_cnt_q);
  assign ram_dout   = wdata_q[{issue_cnt_q[1:0], 3'b000} +: 8];
  assign data       = data_q;

  // Counters, in-flight tracking and word assembly. A freeze only stalls the
  // issue side: bytes already requested from the RAM still land, otherwise
  // the RAM would return the wrong address's byte when the freeze lifts.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      pipe_q      <= '0;
    end else if (start) begin
      busy_q      <= 1'b1;
      base_q      <= start_addr;
      len_q       <= start_len;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      wdata_q     <= start_wdata;
      data_q      <= '0;
      pipe_q      <= '0;
    end else if (stop) begin
      // Dropping the in-flight bits discards late bytes of an aborted fetch
      busy_q <= 1'b0;
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= issuing && rdy;
      for (int i = 1; i < RAM_RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      if (issuing && rdy) issue_cnt_q <= issue_cnt_q + 3'd1;
      if (capture) begin
        data_q[{cap_cnt_q[1:0], 3'b000} +: 8] <= ram_din;
        cap_cnt_q <= cap_cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Main-RAM arbiter: sole owner of the byte-wide RAM port, shared between
// icache refill and MEM-stage loads/stores (MEM has priority, no preemption).
// Optional feature macro: MEM_ARB_PREFETCH_EN -- after a demand refill of PC p,
// speculatively refill p+4 when otherwise idle; any request or flush aborts it.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RAM_RD_LAT = RAM_RD_LAT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rdy,
  mem_arbiter_if.slave   bus
);

  arb_state_e        state_q, state_d;
  logic [31:0]       pc_q;
  logic              start, stop, start_if;
  logic [31:0]       start_addr;
  logic [2:0]        start_len;
  logic              icache_we, mem_done;
  logic              if_abort;
  logic              issuing, issue_done, cap_done;
  logic [31:0]       seq_data;
  logic [ADDR_W-1:0] seq_ram_a;
  logic [7:0]        seq_dout;
  logic              unused_addr_hi;

  // RAM addresses are only ADDR_W wide; the upper request bits are dropped
  assign unused_addr_hi = ^start_addr[31:ADDR_W];

`ifdef MEM_ARB_PREFETCH_EN
  logic pf_pending_q, pf_active_q, pf_start;
  assign if_abort = bus.if_flush_i ||
                    (pf_active_q && (bus.mem_req_i || bus.if_miss_i));
`else
  assign if_abort = bus.if_flush_i;
`endif

  // Next-state, sequencer control and completion pulses; everything holds
  // while rdy is low, which also defers the done/we pulses.
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    stop       = 1'b0;
    start_if   = 1'b0;
    start_addr = '0;
    start_len  = '0;
    icache_we  = 1'b0;
    mem_done   = 1'b0;
`ifdef MEM_ARB_PREFETCH_EN
    pf_start   = 1'b0;
`endif
    if (rdy) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.mem_req_i) begin
            start      = 1'b1;
            start_addr = bus.mem_addr_i;
            start_len  = sel_to_len(bus.mem_sel_i);
            state_d    = bus.mem_we_i ? ST_MEM_WR : ST_MEM_RD;
          end else if (bus.if_miss_i && !bus.if_flush_i) begin
            start      = 1'b1;
            start_if   = 1'b1;
            start_addr = bus.if_pc_i;
            start_len  = IF_LEN;
            state_d    = ST_IF_RD;
          end
`ifdef MEM_ARB_PREFETCH_EN
          else if (pf_pending_q && !bus.if_flush_i) begin
            start      = 1'b1;
            start_if   = 1'b1;
            pf_start   = 1'b1;
            start_addr = pc_q + 32'd4;
            start_len  = IF_LEN;
            state_d    = ST_IF_RD;
          end
`endif
        end
        ST_IF_RD: begin
          if (if_abort) begin
            stop    = 1'b1;
            state_d = ST_IDLE;
          end else if (cap_done) begin
            icache_we = 1'b1;
            stop      = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_MEM_RD: begin
          if (cap_done) begin
            mem_done = 1'b1;
            stop     = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_MEM_WR: begin
          if (issue_done) begin
            mem_done = 1'b1;
            stop     = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register and refill PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_if) pc_q <= start_addr;
    end
  end

`ifdef MEM_ARB_PREFETCH_EN
  // Prefetch bookkeeping: only a demand refill arms the next-word prefetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_pending_q <= 1'b0;
      pf_active_q  <= 1'b0;
    end else begin
      if (icache_we && !pf_active_q) pf_pending_q <= 1'b1;
      else if (pf_start)             pf_pending_q <= 1'b0;
      if (pf_start)  pf_active_q <= 1'b1;
      else if (stop) pf_active_q <= 1'b0;
    end
  end
`endif

  mem_arbiter_ram_byte_seq #(
    .ADDR_W     (ADDR_W),
    .RAM_RD_LAT (RAM_RD_LAT)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .start       (start),
    .stop        (stop),
    .start_addr  (start_addr[ADDR_W-1:0]),
    .start_len   (start_len),
    .start_wdata (bus.mem_wdata_i),
    .ram_din     (bus.ram_din_i),
    .ram_a       (seq_ram_a),
    .ram_dout    (seq_dout),
    .issuing     (issuing),
    .issue_done  (issue_done),
    .cap_done    (cap_done),
    .data        (seq_data)
  );

  assign bus.icache_we_o    = icache_we;
  assign bus.icache_wpc_o   = pc_q;
  assign bus.icache_winst_o = seq_data;
  assign bus.mem_rdata_o    = seq_data;
  assign bus.mem_done_o     = mem_done;
  assign bus.ram_a_o        = seq_ram_a;
  assign bus.ram_wr_o       = (state_q == ST_MEM_WR) && issuing && rdy;
  assign bus.ram_dout_o     = seq_dout;

endmodule
